// File: rtl/rr_onehot_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, enable and
// hold-limit timeout pulse; every grant is followed by at least one idle cycle.
module rr_onehot_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       en,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] own, own_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] gnt_n;
    logic       en_n;
    logic       timeout_n;

    logic [1:0] pick;
    logic       found;
    logic       rel_done, rel_drop, rel_hold;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                pick  = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    assign rel_done = done;
    assign rel_drop = ~req[own];
    assign rel_hold = (cnt == HOLD_LAST);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        own_n     = own;
        cnt_n     = cnt;
        gnt_n     = gnt;
        en_n      = en;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                en_n  = 1'b0;
                if (found) begin
                    state_n = GRANT;
                    own_n   = pick;
                    cnt_n   = '0;
                    gnt_n   = 4'b0001 << pick;
                    en_n    = 1'b1;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_hold) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    en_n      = 1'b0;
                    ptr_n     = own + 2'd1;
                    timeout_n = rel_hold && !rel_done && !rel_drop;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            own     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            en      <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            own     <= own_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            en      <= en_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter_4.sv
// Directed bench for rr_onehot_arbiter_4: vector table plus hand sequences for
// reset, rotation and MAX_HOLD=1 behaviour, with per-cycle output invariants.
module tb_rr_onehot_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       en;
    logic       timeout;

    logic [3:0] req1 = '0;
    logic       done1 = 1'b0;
    logic [3:0] gnt1;
    logic       en1;
    logic       timeout1;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned run = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    rr_onehot_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .en(en), .timeout(timeout)
    );

    rr_onehot_arbiter_4 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
        .gnt(gnt1), .en(en1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic d, input logic [3:0] g, input logic t);
        vecs.push_back('{req: r, done: d, gnt: g, to: t});
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] g, input logic t,
                        input string name);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        check({name, ".gnt"}, gnt, g);
        check({name, ".en"}, {3'b0, en}, {3'b0, (g != 4'b0)});
        check({name, ".timeout"}, {3'b0, timeout}, {3'b0, t});
    endtask

    // Invariants sampled mid-cycle: one-hot-or-zero, en tracks gnt, bounded grant length.
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            check("inv.onehot", {3'b0, ((gnt & (gnt - 4'd1)) == 4'b0)}, 4'd1);
            check("inv.en", {3'b0, en}, {3'b0, (gnt != 4'b0)});
            check("inv1.en", {3'b0, en1}, {3'b0, (gnt1 != 4'b0)});
            run = en ? run + 1 : 0;
            check("inv.hold", {3'b0, (run <= 8)}, 4'd1);
        end
    end

    initial begin
        // Single request, done after three grant cycles, re-grant after one idle.
        add(4'b0010, 0, 4'b0010, 0);
        add(4'b0010, 0, 4'b0010, 0);
        add(4'b0010, 0, 4'b0010, 0);
        add(4'b0010, 1, 4'b0000, 0);
        add(4'b0010, 0, 4'b0010, 0);
        add(4'b0010, 1, 4'b0000, 0);
        // ptr=2 with req=0101 picks requester 2; dropping req releases.
        add(4'b0101, 0, 4'b0100, 0);
        add(4'b0000, 0, 4'b0000, 0);
        // ptr=3: all requesting, rotation continues 3, 0, 1.
        add(4'b1111, 0, 4'b1000, 0);
        add(4'b1111, 1, 4'b0000, 0);
        add(4'b1111, 0, 4'b0001, 0);
        add(4'b1111, 0, 4'b0001, 0);
        add(4'b1111, 1, 4'b0000, 0);
        add(4'b1111, 0, 4'b0010, 0);
        add(4'b0000, 0, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0);
        // Hold limit: exactly 8 grant cycles, then a timeout idle, then re-grant.
        for (int i = 0; i < 8; i++) add(4'b1000, 0, 4'b1000, 0);
        add(4'b1000, 0, 4'b0000, 1);
        add(4'b1000, 0, 4'b1000, 0);
        // Done and dropped request on the hold-limit edge: release without timeout.
        for (int i = 0; i < 7; i++) add(4'b1000, 0, 4'b1000, 0);
        add(4'b0000, 1, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt", gnt, 4'b0000);
        check("reset.en", {3'b0, en}, 4'b0);
        check("reset.timeout", {3'b0, timeout}, 4'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].to, $sformatf("vec%0d", i));

        // Asynchronous reset mid-grant.
        step(4'b0100, 0, 4'b0100, 0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.gnt", gnt, 4'b0000);
        check("async_rst.en", {3'b0, en}, 4'b0);
        check("async_rst.timeout", {3'b0, timeout}, 4'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Rotation from reset with two-cycle grants: 0, 1, 2, 3, 0.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 0, 4'b0001 << (k % 4), 0, $sformatf("rot%0d.a", k));
            step(4'b1111, 0, 4'b0001 << (k % 4), 0, $sformatf("rot%0d.b", k));
            step(4'b1111, 1, 4'b0000, 0, $sformatf("rot%0d.rel", k));
        end
        step(4'b0000, 0, 4'b0000, 0, "rot.end");

        // MAX_HOLD=1: one-cycle grants alternating with timeout idles.
        req1 = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("mh1_%0d.gnt", k), gnt1, 4'b0001);
            check($sformatf("mh1_%0d.to", k), {3'b0, timeout1}, 4'b0);
            @(posedge clk);
            #1;
            check($sformatf("mh1_%0d.gnt_idle", k), gnt1, 4'b0000);
            check($sformatf("mh1_%0d.to_idle", k), {3'b0, timeout1}, 4'b1);
        end
        // Done on the single grant cycle suppresses timeout.
        @(posedge clk);
        #1;
        check("mh1_done.gnt", gnt1, 4'b0001);
        done1 = 1'b1;
        @(posedge clk);
        #1;
        done1 = 1'b0;
        req1  = 4'b0000;
        check("mh1_done.gnt_idle", gnt1, 4'b0000);
        check("mh1_done.to", {3'b0, timeout1}, 4'b0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter_4.md
# rr_onehot_arbiter_4

Four-requester round-robin arbiter that produces a registered one-hot grant vector plus an enable, directly driving the data and enable inputs of the 4-to-2 enable encoder. Grants are bounded in length and always separated by one idle cycle, so the encoder always sees a clean one-hot word or `en=0` and never a multi-hot pattern. The block sits between the requesting units and the encoder stage in the select-path datapath.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may hold a grant. Legal range 1..255.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Forces all state to reset values immediately; deassertion is synchronous to `clk`.
- `req` input 4: request lines. Bit i set means requester i wants ownership.
- `done` input 1: the current owner releases its grant. Ignored when nothing is granted.
- `gnt` output 4: registered grant. Either all-zero or exactly one bit set. Connects to encoder `d`.
- `en` output 1: registered. Always equals the OR of the `gnt` bits. Connects to encoder `en`.
- `timeout` output 1: registered one-cycle pulse when a grant was ended only by the hold limit.

## Operation
- State: FSM {IDLE, GRANT}, 2-bit rotating pointer `ptr`, 2-bit owner index `own`, and a hold counter `cnt` of 8 bits (ceil(log2(MAX_HOLD)) bits is also acceptable).
- Reset values: state=IDLE, `gnt`=0000, `en`=0, `timeout`=0, `ptr`=0, `own`=0, `cnt`=0.
- IDLE:
  - If `req`=0000, stay in IDLE with `gnt`=0000.
  - Otherwise scan `req` in the order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4) and select the first set bit, i.
  - Next edge: `gnt`=one-hot(i), `en`=1, `own`=i, `cnt`=0, state=GRANT.
- GRANT: on each edge, evaluate the release conditions:
  - (a) `done`=1;
  - (b) `req[own]`=0;
  - (c) `cnt`=MAX_HOLD-1.
- If any release condition holds:
  - Next state is IDLE with `gnt`=0000 and `en`=0.
  - `ptr`=`own`+1 (mod 4, so 3 wraps to 0).
  - `timeout`=1 only if (c) holds and neither (a) nor (b) holds; otherwise `timeout`=0.
- If no release condition holds: `cnt`=`cnt`+1 and `gnt` is unchanged.
- Requests from non-owners during GRANT are ignored. Arbitration happens only in IDLE, so there is no preemption.
- `timeout` is 0 in every cycle other than the single IDLE cycle that follows a timeout release.
- With a single continuous requester, that requester is re-granted after each one-cycle idle gap.
- With all four requesting, grant order from reset is 0, 1, 2, 3, 0, …

## Timing
- Latency: `req` sampled at edge N in IDLE produces `gnt`/`en` valid after edge N.
- Grant length:
  - Maximum is MAX_HOLD cycles.
  - MAX_HOLD=1 gives exactly one-cycle grants.
  - `done` sampled in the first GRANT cycle gives a one-cycle grant.
- At least one cycle with `en`=0 separates any two grants, including back-to-back grants to the same requester.
- Simultaneous release events: `done`, dropped request and hold limit on the same edge count as a single release; `timeout`=0 in that case.
- `rst_n` low mid-grant clears `gnt`/`en` asynchronously, without waiting for a clock edge. After release, arbitration restarts with `ptr`=0.
- Outputs come straight from flops, with no combinational path from inputs.

## Test plan
- Reset: assert `rst_n`=0 mid-GRANT with `gnt`=0100 → `gnt`=0000, `en`=0, `timeout`=0 immediately. Release reset, then set `req`=1111 → first `gnt`=0001.
- Single request: `req`=0010 at edge N, then `done` pulse at edge N+3 → `gnt`=0010 for 3 cycles, then 0000 for 1 cycle, then 0010 again if `req` is still held.
- Rotation: `req`=1111, MAX_HOLD=8, `done` pulsed after 2 grant cycles each time → `gnt` sequence 0001, 0010, 0100, 1000, 0001, each grant separated by an idle cycle.
- Timeout: `req`=1000 held, `done`=0, MAX_HOLD=8 → `gnt`=1000 for exactly 8 cycles, then `timeout`=1 and `en`=0 for 1 cycle, then `ptr`=0 and `gnt`=1000 is re-granted.
- Simultaneous events: `done`=1 and `req[own]` dropped on the edge where `cnt`=MAX_HOLD-1 → release occurs, `timeout`=0. Separately, `req`=0101 with `ptr`=2 → grant goes to 0100.
- Invariant check, all tests: `gnt` is zero or one-hot every cycle, `en`==|`gnt`, and grant length ≤ MAX_HOLD.
